// File: rtl/layer5_argmax.sv
// Iterative argmax over ReLU-clamped float32 node outputs: one word compared per clock.
// Latency NUM_NODES cycles from start to done; start is ignored while busy (no queueing).
module layer5_argmax #(
  parameter int NUM_NODES = 6,
  parameter int IDX_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_NODES*32-1:0] node_bus,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        class_idx,
  output logic [31:0]             max_val
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NODES - 1);

  state_t                  state, state_nxt;
  logic [NUM_NODES*32-1:0] snap;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        best_idx;
  logic [31:0]             best;
  logic [31:0]             cur;
  logic [31:0]             cur_clamped;
  logic                    load, step, fin;

  // Non-negative IEEE floats order the same as their unsigned bit patterns.
  function automatic logic [31:0] clamp(input logic [31:0] w);
    return w[31] ? 32'h0000_0000 : w;
  endfunction

  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_NODES; k++) begin
      if (ptr == IDX_W'(k)) cur = snap[32*k +: 32];
    end
    cur_clamped = clamp(cur);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (NUM_NODES == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        step = 1'b1;
        if (ptr == LAST) state_nxt = DONE;
      end
      DONE: begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      ptr       <= '0;
      best      <= '0;
      best_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_idx <= '0;
      max_val   <= '0;
    end else begin
      done <= fin;
      if (load) begin
        snap     <= node_bus;
        best     <= clamp(node_bus[31:0]);
        best_idx <= '0;
        ptr      <= IDX_W'(1);
        busy     <= 1'b1;
      end else if (state == IDLE && done) begin
        // The done cycle is spent in IDLE so a start on the following edge is accepted.
        busy <= 1'b0;
      end
      if (step) begin
        if (cur_clamped > best) begin
          best     <= cur_clamped;
          best_idx <= ptr;
        end
        ptr <= ptr + IDX_W'(1);
      end
      if (fin) begin
        class_idx <= best_idx;
        max_val   <= best;
      end
    end
  end

endmodule

// File: tb/tb_layer5_argmax.sv
// Directed bench for layer5_argmax: default 6-node instance plus a single-node instance.
module tb_layer5_argmax;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [191:0] node_bus;
  logic         busy, done;
  logic [2:0]   class_idx;
  logic [31:0]  max_val;

  logic         start1;
  logic [31:0]  bus1;
  logic         busy1, done1;
  logic [0:0]   idx1;
  logic [31:0]  val1;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  bit seen_done;

  localparam logic [191:0] BUS_A =
    {32'h0000_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000};

  layer5_argmax #(.NUM_NODES(6), .IDX_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .node_bus(node_bus),
    .busy(busy), .done(done), .class_idx(class_idx), .max_val(max_val)
  );

  layer5_argmax #(.NUM_NODES(1), .IDX_W(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .node_bus(bus1),
    .busy(busy1), .done(done1), .class_idx(idx1), .max_val(val1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge (E0), then count edges until done is seen (bounded).
  task automatic run(input logic [191:0] bus, input logic [2:0] ei, input logic [31:0] ev,
                     input string tag);
    node_bus = bus;
    start    = 1'b1;
    step();
    start    = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd6);
    chk({tag, "_idx"}, 32'(class_idx), 32'(ei));
    chk({tag, "_val"}, max_val, ev);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_idx_hold"}, 32'(class_idx), 32'(ei));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    start1   = 1'b0;
    node_bus = '0;
    bus1     = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_val", max_val, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic scan: 2.0 at index 2 wins.
    run(BUS_A, 3'd2, 32'h4000_0000, "basic");
    // Ties keep the lowest index.
    run({6{32'h3F80_0000}}, 3'd0, 32'h3F80_0000, "ties");
    // Negative word0 clamps to zero; zeros never beat it.
    run({{5{32'h0000_0000}}, 32'hC040_0000}, 3'd0, 32'h0000_0000, "neg0");
    run({32'h3F00_0000, {4{32'h0000_0000}}, 32'hC040_0000}, 3'd5, 32'h3F00_0000, "neg5");
    // Infinity pattern compares as largest; -0 in word0 clamps.
    run({32'h3F80_0000, 32'h7F80_0000, 32'h4000_0000, 32'h0, 32'h0, 32'h8000_0000},
        3'd4, 32'h7F80_0000, "inf");

    // Snapshot: bus change and re-start during SCAN are ignored.
    node_bus = BUS_A;
    start    = 1'b1;
    step();                       // E0
    start    = 1'b0;
    step();                       // E1
    lat      = 1;
    node_bus = {6{32'h7F00_0000}};
    start    = 1'b1;
    step();                       // E2
    lat++;
    start    = 1'b0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    chk("snap_latency", 32'(lat), 32'd6);
    chk("snap_idx", 32'(class_idx), 32'd2);
    chk("snap_val", max_val, 32'h4000_0000);
    start = 1'b1;
    step();                       // E7: accepted
    start = 1'b0;
    chk("snap_single_done", 32'(done), 32'd0);
    chk("snap_restart_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    chk("snap2_latency", 32'(lat), 32'd6);
    chk("snap2_idx", 32'(class_idx), 32'd0);
    chk("snap2_val", max_val, 32'h7F00_0000);
    step();

    // Reset mid-scan aborts without a done pulse.
    node_bus = BUS_A;
    start    = 1'b1;
    step();                       // E0
    start    = 1'b0;
    step();                       // E1
    step();                       // E2
    @(posedge clk);               // E3
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_idx", 32'(class_idx), 32'd0);
    chk("abort_val", max_val, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    run(BUS_A, 3'd2, 32'h4000_0000, "after_rst");

    // Single-node instance: done one cycle after the start edge.
    bus1   = 32'h3F80_0000;
    start1 = 1'b1;
    step();                       // E0
    start1 = 1'b0;
    chk("one_busy_e0", 32'(busy1), 32'd1);
    chk("one_done_e0", 32'(done1), 32'd0);
    step();                       // E1
    chk("one_done_e1", 32'(done1), 32'd1);
    chk("one_idx", 32'(idx1), 32'd0);
    chk("one_val", val1, 32'h3F80_0000);
    step();                       // E2
    chk("one_done_drop", 32'(done1), 32'd0);
    chk("one_busy_drop", 32'(busy1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
